// File: rtl/fir_fifo_pkg.sv
// rtl/fir_fifo_pkg.sv - shared sample and drop-counter definitions for the FIR sample FIFO
package fir_fifo_pkg;
    localparam int SAMPLE_W = 16;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/fir_fifo_ram.sv
// rtl/fir_fifo_ram.sv - DEPTH x DATA_W storage, synchronous write, asynchronous read
module fir_fifo_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/fir_sample_fifo.sv
// rtl/fir_sample_fifo.sv - FWFT output buffer for FIR samples with drop counting
// Optional peak-occupancy tracking is enabled by defining FIR_FIFO_PEAK_EN.
module fir_sample_fifo #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     m_valid,
    output logic [DATA_W-1:0]        m_data,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   peak_level
);
    import fir_fifo_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] AFULL_V = (AW+1)'(AFULL_LVL);

    logic [AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_nxt, level_q;
    logic        empty_q, full_q, afull_q, overflow_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DATA_W-1:0]     rd_data;
    logic        pop, push, drop;

    assign pop  = !empty_q && m_ready;
    assign push = valid_in && (!full_q || pop) && !flush;
    assign drop = valid_in && full_q && !pop && !flush;

    always_comb begin
        wr_nxt = wr_ptr;
        rd_nxt = rd_ptr;
        if (flush) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end else begin
            if (push) wr_nxt = wr_ptr + PTR_ONE;
            if (pop)  rd_nxt = rd_ptr + PTR_ONE;
        end
    end

    // Wrap-bit arithmetic: the pointer difference is exactly the occupancy 0..DEPTH.
    assign level_nxt = wr_nxt - rd_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr  <= wr_nxt;
            rd_ptr  <= rd_nxt;
            level_q <= level_nxt;
            empty_q <= (wr_nxt == rd_nxt);
            full_q  <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
            afull_q <= (level_nxt >= AFULL_V);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != DROP_CNT_MAX) begin
                    drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                end
            end
        end
    end

`ifdef FIR_FIFO_PEAK_EN
    logic [AW:0] peak_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (level_nxt > peak_q) begin
            peak_q <= level_nxt;
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = '0;
`endif

    fir_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we      (push),
        .wr_idx  (wr_ptr[AW-1:0]),
        .wr_data (data_in),
        .rd_idx  (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    // Storage is not reset, so the head is masked to zero while nothing is buffered.
    assign m_valid     = !empty_q;
    assign m_data      = empty_q ? '0 : rd_data;
    assign level       = level_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_fir_sample_fifo.sv
// tb/tb_fir_sample_fifo.sv - scoreboard bench for fir_sample_fifo (honours FIR_FIFO_PEAK_EN)
module tb_fir_sample_fifo;
    import fir_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic        clk = 1'b0;
    logic        rst_n, flush, valid_in, m_ready;
    sample_t     data_in;
    logic        m_valid;
    logic [15:0] m_data;
    logic [4:0]  level, peak_level;
    logic        empty, full, almost_full, overflow;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] sb[$];
    int          mlevel, mdrop, mpeak;
    bit          movf;

    always #5 clk = ~clk;

    fir_sample_fifo #(.DATA_W(16), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .peak_level  (peak_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        chk("level", 32'(level), 32'(mlevel));
        chk("empty", 32'(empty), 32'(mlevel == 0));
        chk("full", 32'(full), 32'(mlevel == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(mlevel >= AFULL));
        chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("peak_level", 32'(peak_level), 32'(mpeak));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; m_ready = 1'b0; data_in = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        mlevel = 0; mdrop = 0; mpeak = 0; movf = 1'b0;
        chk_status();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
    endtask

    // One clock: drive inputs, check the head against the scoreboard, advance the model.
    task automatic cycle(input bit vin, input logic [15:0] din, input bit rdy, input bit fl);
        bit pop;
        valid_in = vin; data_in = din; m_ready = rdy; flush = fl;
        #1;
        chk("m_valid", 32'(m_valid), 32'(mlevel != 0));
        pop = (mlevel != 0) && rdy;
        if (pop) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("head", 32'(m_data), 32'(sb[0]));
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (vin && (mlevel < DEPTH || pop)) begin
                sb.push_back(din);
            end else if (vin) begin
                movf = 1'b1;
                if (mdrop != 32'hFFFF) mdrop++;
            end
        end
        mlevel = sb.size();
`ifdef FIR_FIFO_PEAK_EN
        if (mlevel > mpeak) mpeak = mlevel;
`endif
        @(posedge clk); #1;
        valid_in = 1'b0; m_ready = 1'b0; flush = 1'b0;
        chk_status();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; m_ready = 1'b0; data_in = '0;
        do_reset();

        // Basic FWFT ordering
        cycle(1, 16'h7FFF, 0, 0);
        cycle(1, 16'h8000, 0, 0);
        cycle(1, 16'h2000, 0, 0);
        chk("t1_level", 32'(level), 32'd3);
        chk("t1_head", 32'(m_data), 32'h7FFF);
        for (int i = 0; i < 3; i++) cycle(0, 16'h0, 1, 0);
        chk("t1_empty", 32'(empty), 32'd1);

        // Fill, almost_full threshold, overflow drop
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 16'(i), 0, 0);
            chk("t2_af_ramp", 32'(almost_full), 32'(i >= 12));
        end
        chk("t2_full", 32'(full), 32'd1);
        cycle(1, 16'hAAAA, 0, 0);
        chk("t2_drop", 32'(drop_cnt), 32'd1);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_head", 32'(m_data), 32'h0001);

        // Push+pop while full: no drop, level stays DEPTH
        cycle(1, 16'h5555, 1, 0);
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_drop", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 15; i++) cycle(0, 16'h0, 1, 0);
        chk("t3_last", 32'(m_data), 32'h5555);
        cycle(0, 16'h0, 1, 0);

        // Write into empty FIFO is not poppable in the same cycle
        cycle(1, 16'hABCD, 1, 0);
        chk("t4_valid", 32'(m_valid), 32'd1);
        chk("t4_data", 32'(m_data), 32'hABCD);
        cycle(0, 16'h0, 1, 0);
        chk("t4_empty", 32'(empty), 32'd1);

        // Flush with coincident valid_in
        for (int i = 0; i < 5; i++) cycle(1, 16'(16'h0100 + i), 0, 0);
        cycle(1, 16'h9999, 0, 1);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_valid", 32'(m_valid), 32'd0);
        chk("t5_drop", 32'(drop_cnt), 32'd1);
        cycle(1, 16'h1234, 0, 0);
        chk("t5_head", 32'(m_data), 32'h1234);
        cycle(0, 16'h0, 1, 0);

        // Peak level tracking
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1, 16'(16'h0200 + i), 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 16'h0, 1, 0);
`ifdef FIR_FIFO_PEAK_EN
        chk("t6_peak_drain", 32'(peak_level), 32'd9);
`else
        chk("t6_peak_drain", 32'(peak_level), 32'd0);
`endif
        cycle(0, 16'h0, 0, 1);
`ifdef FIR_FIFO_PEAK_EN
        chk("t6_peak_flush", 32'(peak_level), 32'd9);
`else
        chk("t6_peak_flush", 32'(peak_level), 32'd0);
`endif

        // Reset mid-stream discards contents; next sample stored normally
        for (int i = 0; i < 3; i++) cycle(1, 16'(16'h0300 + i), 0, 0);
        do_reset();
        chk("t7_peak_rst", 32'(peak_level), 32'd0);
        cycle(1, 16'h4321, 0, 0);
        chk("t7_level", 32'(level), 32'd1);
        chk("t7_head", 32'(m_data), 32'h4321);
        cycle(0, 16'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
